// File: rtl/lfsr_prng.sv
// Parametrised Galois LFSR word generator with decimation, run-time seeding
// (zero seeds replaced by SEED) and a valid/ready output stream.
module lfsr_prng #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = 32'h0040_0006,
  parameter logic [WIDTH-1:0] SEED  = 32'hFFFF_FFFF,
  parameter int               STEPS = 1,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seed_err,
  output logic [CNT_W-1:0] out_count
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  // Stage 0 always takes the feedback bit, whatever POLY[0] says.
  localparam logic [WIDTH-1:0] TAPS = {POLY[WIDTH-1:1], 1'b1};

  logic [WIDTH-1:0] state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] step_nxt;
  logic             accept, stall, shift, last, seed_zero;

  assign step_nxt  = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? TAPS : '0);
  assign accept    = valid_q & out_ready;
  assign stall     = valid_q & ~out_ready;
  assign shift     = en & ~stall;
  assign last      = (cnt_q == CW'(STEPS - 1));
  assign seed_zero = (seed_in == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    err_d   = 1'b0;
    // Accept first so a completing word below can re-raise valid without a bubble.
    if (accept) begin
      count_d = count_q + CNT_W'(1);
      valid_d = 1'b0;
    end
    if (seed_load) begin
      state_d = seed_zero ? SEED : seed_in;
      cnt_d   = '0;
      valid_d = 1'b0;
      err_d   = seed_zero;
    end else if (shift) begin
      state_d = step_nxt;
      if (last) begin
        cnt_d   = '0;
        data_d  = step_nxt;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign seed_err  = err_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: default, STEPS=2 and 4-bit instances checked against
// a multiply-by-x-mod-P(x) reference model, vector table and random backpressure.
module tb_lfsr_prng;

  logic        clk;
  logic        rst, en, seed_load, out_ready;
  logic [31:0] seed_in;
  logic [3:0]  s4;

  logic [31:0] d0, d1;
  logic        v0, v1, e0, e1;
  logic [15:0] c0, c1;
  logic [3:0]  d2, c2;
  logic        v2, e2;

  int n_cmp = 0;
  int n_fail = 0;

  lfsr_prng u0 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_data(d0), .out_valid(v0), .out_ready(out_ready), .seed_err(e0), .out_count(c0)
  );

  lfsr_prng #(.STEPS(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready), .seed_err(e1), .out_count(c1)
  );

  lfsr_prng #(.WIDTH(4), .POLY(4'h2), .SEED(4'h1), .STEPS(1), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(s4),
    .out_data(d2), .out_valid(v2), .out_ready(out_ready), .seed_err(e2), .out_count(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one LFSR shift is multiplication by x modulo P(x) = x^w + poly + 1.
  function automatic logic [63:0] mulx(input logic [63:0] v, input int w, input logic [63:0] p);
    logic [63:0] m;
    logic [63:0] t;
    m = (64'd1 << w) - 64'd1;
    t = v << 1;
    if (((t >> w) & 64'd1) != 0) t = t ^ (p | 64'd1);
    return t & m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; seed_load = 1'b0; out_ready = 1'b0; seed_in = '0; s4 = '0;
    step();
    chk("rst_data0", 64'(d0), 0);  chk("rst_valid0", 64'(v0), 0);
    chk("rst_err0", 64'(e0), 0);   chk("rst_cnt0", 64'(c0), 0);
    chk("rst_valid1", 64'(v1), 0); chk("rst_cnt1", 64'(c1), 0);
    chk("rst_valid2", 64'(v2), 0); chk("rst_data2", 64'(d2), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en, rdy, ld;
    logic [31:0] sd;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    logic [15:0] ec;
  } vec_t;

  vec_t tv[12];

  localparam logic [63:0] P32 = 64'h0040_0006;

  initial begin
    logic [63:0] s0, s1, s;
    logic [31:0] pd0, pd1;
    logic        pv0, pv1, pr;
    int          hs0, hs1;
    logic [3:0]  w[32];
    logic [15:0] mask;

    //            en    rdy   ld    seed          ev    data           err   count
    tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFBF_FFF9, 1'b0, 16'd0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFF3F_FFF5, 1'b0, 16'd1};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFF3F_FFF5, 1'b0, 16'd1};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,         1'b1, 16'd1};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFBF_FFF9, 1'b0, 16'd1};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 32'h1,        1'b0, 32'h0,         1'b0, 16'd2};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0002, 1'b0, 16'd2};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 16'd3};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 16'd4};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 16'd4};
    tv[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 16'd4};
    tv[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 16'd4};

    // Vector table on the default instance.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      en = tv[i].en; out_ready = tv[i].rdy; seed_load = tv[i].ld; seed_in = tv[i].sd;
      step();
      chk($sformatf("tv%0d_valid", i), 64'(v0), 64'(tv[i].ev));
      if (tv[i].ev) chk($sformatf("tv%0d_data", i), 64'(d0), 64'(tv[i].ed));
      chk($sformatf("tv%0d_err", i), 64'(e0), 64'(tv[i].ee));
      chk($sformatf("tv%0d_count", i), 64'(c0), 64'(tv[i].ec));
    end
    // Reset mid-stream while a word is pending.
    seed_load = 1'b0; rst = 1'b1;
    step();
    chk("midrst_valid", 64'(v0), 0); chk("midrst_data", 64'(d0), 0);
    chk("midrst_count", 64'(c0), 0);
    rst = 1'b0;

    // STEPS=2 hand sequence, including en low freezing the step counter.
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    step(); chk("s2_c1_valid", 64'(v1), 0);
    step(); chk("s2_c2_valid", 64'(v1), 1); chk("s2_c2_data", 64'(d1), 64'h0000_0000_FF3F_FFF5);
    en = 1'b0;
    step(); chk("s2_c3_valid", 64'(v1), 0); chk("s2_c3_count", 64'(c1), 1);
    en = 1'b1;
    step(); chk("s2_c4_valid", 64'(v1), 0);
    step();
    s = 64'hFFFF_FFFF;
    repeat (4) s = mulx(s, 32, P32);
    chk("s2_c5_valid", 64'(v1), 1); chk("s2_c5_data", 64'(d1), s);

    // Random en / backpressure on both 32-bit instances against the model.
    do_reset();
    s0 = 64'hFFFF_FFFF; s1 = 64'hFFFF_FFFF; hs0 = 0; hs1 = 0;
    for (int i = 0; i < 1000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      pr = out_ready; pv0 = v0; pd0 = d0; pv1 = v1; pd1 = d1;
      if (pv0 && pr) begin
        s0 = mulx(s0, 32, P32);
        chk("rnd_word0", 64'(pd0), s0);
        hs0++;
      end
      if (pv1 && pr) begin
        s1 = mulx(mulx(s1, 32, P32), 32, P32);
        chk("rnd_word1", 64'(pd1), s1);
        hs1++;
      end
      step();
      if (pv0 && !pr) begin
        chk("stall_data0", 64'(d0), 64'(pd0)); chk("stall_valid0", 64'(v0), 1);
      end
      if (pv1 && !pr) begin
        chk("stall_data1", 64'(d1), 64'(pd1)); chk("stall_valid1", 64'(v1), 1);
      end
      chk("rnd_count0", 64'(c0), 64'(hs0 % 65536));
      chk("rnd_count1", 64'(c1), 64'(hs1 % 65536));
    end
    chk("rnd_progress0", 64'(hs0 > 200), 1);
    chk("rnd_progress1", 64'(hs1 > 100), 1);

    // 4-bit maximal-length sequence and CNT_W=4 wrap.
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    s = 64'h1; mask = '0;
    for (int i = 0; i < 32; i++) begin
      step();
      s = mulx(s, 4, 64'h2);
      w[i] = d2;
      if (i < 15) mask = mask | (16'd1 << d2);
      chk($sformatf("w4_valid%0d", i), 64'(v2), 1);
      chk($sformatf("w4_data%0d", i), 64'(d2), s);
      chk($sformatf("w4_count%0d", i), 64'(c2), 64'(i % 16));
    end
    chk("w4_all_states", 64'(mask), 64'hFFFE);
    chk("w4_period", 64'(w[15]), 64'(w[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
